// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between N_REQ requesters, the arbiter and the register-file write port.
// Carries the requester handshakes, the output write stage and the scoreboard query.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [5*N_REQ-1:0]  req_addr;
  logic [32*N_REQ-1:0] req_data;
  logic [2*N_REQ-1:0]  req_size;
  logic                wr_valid;
  logic                rf_ready;
  logic [4:0]          wr_addr;
  logic [31:0]         wr_data;
  logic [3:0]          wr_be;
  logic [4:0]          query_addr;
  logic                query_busy;

  modport master (
    output req_valid, req_addr, req_data, req_size, rf_ready, query_addr,
    input  req_ready, wr_valid, wr_addr, wr_data, wr_be, query_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, rf_ready, query_addr,
    output req_ready, wr_valid, wr_addr, wr_data, wr_be, query_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates N_REQ write-back requesters onto one registered register-file write port.
// Build option RF_WB_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned PW = $clog2(N_REQ);

  logic          wr_valid_q, wr_valid_d;
  logic [4:0]    wr_addr_q,  wr_addr_d;
  logic [31:0]   wr_data_q,  wr_data_d;
  logic [3:0]    wr_be_q,    wr_be_d;
  logic [PW-1:0] ptr_q;

  logic          slot_free;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;
  logic [1:0]    sel_size;
  logic [3:0]    sel_be;
  logic          busy;

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [PW-1:0] ptr_d;
`endif

  // Two scans give the wrapped search: indices at/after ptr first, then the lowest valid.
  always_comb begin
    slot_free = !wr_valid_q || bus.rf_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (slot_free && !rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!grant_vld && bus.req_valid[i] && (i >= 32'(ptr_q))) begin
          grant_vld = 1'b1;
          grant_idx = PW'(i);
        end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!grant_vld && bus.req_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = PW'(i);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    sel_addr      = '0;
    sel_data      = '0;
    sel_size      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_vld && (grant_idx == PW'(i))) begin
        bus.req_ready[i] = 1'b1;
        sel_addr         = bus.req_addr[5*i +: 5];
        sel_data         = bus.req_data[32*i +: 32];
        sel_size         = bus.req_size[2*i +: 2];
      end
    end
  end

  always_comb begin
    case (sel_size)
      2'b01:   sel_be = 4'b0011;
      2'b10:   sel_be = 4'b0001;
      default: sel_be = 4'b1111;
    endcase
  end

  // A granted r0 beat is consumed but behaves like an idle cycle for the output stage.
  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_be_d    = wr_be_q;
    if (grant_vld && (sel_addr != 5'd0)) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      wr_be_d    = sel_be;
    end else if (bus.rf_ready) begin
      wr_valid_d = 1'b0;
    end
  end

`ifndef RF_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
`ifndef RF_WB_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
`ifndef RF_WB_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  always_comb begin
    busy = wr_valid_q && (wr_addr_q == bus.query_addr);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i] && (bus.req_addr[5*i +: 5] == bus.query_addr)) begin
        busy = 1'b1;
      end
    end
    if (bus.query_addr == 5'd0) begin
      busy = 1'b0;
    end
  end

  assign bus.query_busy = busy;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_be      = wr_be_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, grant order, backpressure, byte enables,
// r0 filter and scoreboard, with hand-computed expectations per cycle.
module tb_regfile_wb_arbiter;
  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(N)) bus ();
  regfile_wb_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [1:0]  s0, s1, s2;
    logic        rfr;
    logic [4:0]  q;
    logic [2:0]  e_rdy;
    logic        e_wv;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic        e_busy;
  } vec_t;

  vec_t tbl [16];

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  localparam logic [2:0]  R12_RDY = 3'b001;
  localparam logic [4:0]  R13_WA  = 5'd10;
  localparam logic [31:0] R13_WD  = 32'h0A0A0A0A;
  logic [2:0] rr_rdy [5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [4:0] rr_wa  [5] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd1};
`else
  localparam logic [2:0]  R12_RDY = 3'b010;
  localparam logic [4:0]  R13_WA  = 5'd11;
  localparam logic [31:0] R13_WD  = 32'h0B0B0B0B;
  logic [2:0] rr_rdy [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [4:0] rr_wa  [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd1};
`endif

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [4:0] a0, a1, a2,
    input logic [31:0] d0, d1, d2, input logic [1:0] s0, s1, s2,
    input logic rfr, input logic [4:0] q, input logic [2:0] e_rdy, input logic e_wv,
    input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [3:0] e_be, input logic e_busy);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.s0 = s0; v.s1 = s1; v.s2 = s2;
    v.rfr = rfr; v.q = q; v.e_rdy = e_rdy; v.e_wv = e_wv;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_be = e_be; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive(input logic [2:0] valid, input logic [4:0] a0, a1, a2,
                       input logic [31:0] d0, d1, d2, input logic [1:0] s0, s1, s2);
    bus.req_valid = valid;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
    bus.req_size  = {s2, s1, s0};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd5, 3'b001, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
    tbl[1]  = mk(3'b010, 5'd0, 5'd6, 5'd0, 32'h0, 32'h11111111, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b0, 5'd5, 3'b000, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = mk(3'b010, 5'd0, 5'd6, 5'd0, 32'h0, 32'h11111111, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd6, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    tbl[5]  = mk(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h000000AB, 32'h0, 2'd0, 2'd2, 2'd0,
                 1'b1, 5'd0, 3'b010, 1'b1, 5'd6, 32'h11111111, 4'hF, 1'b0);
    tbl[6]  = mk(3'b010, 5'd0, 5'd8, 5'd0, 32'h0, 32'h0000CDEF, 32'h0, 2'd0, 2'd1, 2'd0,
                 1'b1, 5'd7, 3'b010, 1'b1, 5'd7, 32'h000000AB, 4'h1, 1'b1);
    tbl[7]  = mk(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h12345678, 32'h0, 2'd0, 2'd3, 2'd0,
                 1'b1, 5'd9, 3'b010, 1'b1, 5'd8, 32'h0000CDEF, 4'h3, 1'b1);
    tbl[8]  = mk(3'b000, 5'd0, 5'd9, 5'd0, 32'h0, 32'h12345678, 32'h0, 2'd0, 2'd3, 2'd0,
                 1'b0, 5'd9, 3'b000, 1'b1, 5'd9, 32'h12345678, 4'hF, 1'b1);
    tbl[9]  = mk(3'b000, 5'd0, 5'd9, 5'd0, 32'h0, 32'h12345678, 32'h0, 2'd0, 2'd3, 2'd0,
                 1'b1, 5'd9, 3'b000, 1'b1, 5'd9, 32'h12345678, 4'hF, 1'b1);
    tbl[10] = mk(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd0, 3'b100, 1'b0, 5'd9, 32'h12345678, 4'hF, 1'b0);
    tbl[11] = mk(3'b111, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd0, 3'b001, 1'b0, 5'd9, 32'h12345678, 4'hF, 1'b0);
    tbl[12] = mk(3'b011, 5'd10, 5'd11, 5'd0, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd11, R12_RDY, 1'b0, 5'd9, 32'h12345678, 4'hF, 1'b1);
    tbl[13] = mk(3'b001, 5'd10, 5'd0, 5'd0, 32'h0A0A0A0A, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd10, 3'b001, 1'b1, R13_WA, R13_WD, 4'hF, 1'b1);
    tbl[14] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd10, 3'b000, 1'b1, 5'd10, 32'h0A0A0A0A, 4'hF, 1'b1);
    tbl[15] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0,
                 1'b1, 5'd10, 3'b000, 1'b0, 5'd10, 32'h0A0A0A0A, 4'hF, 1'b0);

    // Reset held two cycles with every requester asking.
    rst            = 1'b1;
    bus.rf_ready   = 1'b1;
    bus.query_addr = 5'd0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 2'd0, 2'd0, 2'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d_rdy", c), 32'(bus.req_ready), 32'h0);
      chk($sformatf("rst%0d_wv", c), 32'(bus.wr_valid), 32'h0);
    end

    // Continuous requests: grant order and write address one cycle later.
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk($sformatf("rr%0d_rdy", c), 32'(bus.req_ready), 32'(rr_rdy[c]));
      chk($sformatf("rr%0d_wv", c), 32'(bus.wr_valid), (c == 0) ? 32'h0 : 32'h1);
      if (c != 0) chk($sformatf("rr%0d_wa", c), 32'(bus.wr_addr), 32'(rr_wa[c]));
    end

    // Reset mid-operation discards the pending write.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rdy", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("midrst_wv", 32'(bus.wr_valid), 32'h0);
    chk("midrst_wa", 32'(bus.wr_addr), 32'h0);
    chk("midrst_wd", bus.wr_data, 32'h0);
    chk("midrst_be", 32'(bus.wr_be), 32'h0);
    rst = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2,
            tbl[i].s0, tbl[i].s1, tbl[i].s2);
      bus.rf_ready   = tbl[i].rfr;
      bus.query_addr = tbl[i].q;
      #1;
      chk($sformatf("row%0d_rdy", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_wv", i), 32'(bus.wr_valid), 32'(tbl[i].e_wv));
      chk($sformatf("row%0d_wa", i), 32'(bus.wr_addr), 32'(tbl[i].e_wa));
      chk($sformatf("row%0d_wd", i), bus.wr_data, tbl[i].e_wd);
      chk($sformatf("row%0d_be", i), 32'(bus.wr_be), 32'(tbl[i].e_be));
      chk($sformatf("row%0d_busy", i), 32'(bus.query_busy), 32'(tbl[i].e_busy));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
